// File: rtl/stream_accum_alu_if.sv
// Valid/ready operand and result streams of the accumulator ALU.
// The master side drives operands and consumes results; the slave side is the ALU.
interface stream_accum_alu_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_carry;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/stream_accum_alu.sv
// Registered unsigned ALU/accumulator with a one-deep result register.
// Modes: ADD, SUB, ACC (running sum with wrap or saturate), LOAD (LOAD 0+0 clears).
module stream_accum_alu #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,  // must be >= WIDTH+1
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_accum_alu_if.slave    bus,
  output logic                 ovf_sticky,
  output logic [CNT_WIDTH-1:0] sample_count
);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef logic [ACC_WIDTH:0]   acc_ext_t;

  acc_t                 acc;
  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  acc_ext_t             acc_sum;
  logic                 acc_ovf;
  acc_t                 res_data;
  logic                 res_carry;
  acc_t                 acc_next;
  logic                 sticky_next;
  logic [CNT_WIDTH-1:0] count_next;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Both operand paths are one bit wider so the top bit is carry or borrow.
  assign add_sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign sub_diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign acc_sum  = {1'b0, acc} + acc_ext_t'(add_sum);
  assign acc_ovf  = acc_sum[ACC_WIDTH];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    res_data    = '0;
    res_carry   = 1'b0;
    acc_next    = acc;
    sticky_next = ovf_sticky;
    count_next  = sample_count;
    unique case (mode_e'(bus.in_mode))
      MODE_ADD: begin
        res_data  = acc_t'(add_sum);
        res_carry = add_sum[WIDTH];
      end
      MODE_SUB: begin
        res_data  = acc_t'(sub_diff[WIDTH-1:0]);
        res_carry = sub_diff[WIDTH];
      end
      MODE_ACC: begin
        acc_next    = (acc_ovf && SATURATE) ? '1 : acc_sum[ACC_WIDTH-1:0];
        res_data    = acc_next;
        res_carry   = acc_ovf;
        sticky_next = ovf_sticky | acc_ovf;
        count_next  = sample_count + 1'b1;
      end
      MODE_LOAD: begin
        acc_next    = acc_t'(add_sum);
        res_data    = acc_next;
        sticky_next = 1'b0;
        count_next  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_carry <= 1'b0;
      acc           <= '0;
      ovf_sticky    <= 1'b0;
      sample_count  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= res_data;
      bus.out_carry <= res_carry;
      acc           <= acc_next;
      ovf_sticky    <= sticky_next;
      sample_count  <= count_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_accum_alu.sv
// Bench for stream_accum_alu: four parameterisations behind one shared stimulus
// port, a vector table feeding a result scoreboard, plus backpressure and reset sequences.
module tb_stream_accum_alu;

  localparam logic [1:0] M_ADD = 2'd0, M_SUB = 2'd1, M_ACC = 2'd2, M_LOAD = 2'd3;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        carry;
    logic        sticky;
    logic [7:0]  count;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        sticky;
    logic [7:0]  count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [1:0] in_mode;
  logic [1:0] sel;

  stream_accum_alu_if #(.WIDTH(8), .ACC_WIDTH(16)) if0 ();
  stream_accum_alu_if #(.WIDTH(8), .ACC_WIDTH(9))  if1 ();
  stream_accum_alu_if #(.WIDTH(8), .ACC_WIDTH(9))  if2 ();
  stream_accum_alu_if #(.WIDTH(8), .ACC_WIDTH(16)) if3 ();

  logic       st0, st1, st2, st3;
  logic [7:0] cn0, cn1, cn2;
  logic [1:0] cn3;

  stream_accum_alu #(.WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0), .CNT_WIDTH(8)) u_def (
    .clk(clk), .rst(rst), .bus(if0), .ovf_sticky(st0), .sample_count(cn0));
  stream_accum_alu #(.WIDTH(8), .ACC_WIDTH(9), .SATURATE(1'b0), .CNT_WIDTH(8)) u_wrap9 (
    .clk(clk), .rst(rst), .bus(if1), .ovf_sticky(st1), .sample_count(cn1));
  stream_accum_alu #(.WIDTH(8), .ACC_WIDTH(9), .SATURATE(1'b1), .CNT_WIDTH(8)) u_sat9 (
    .clk(clk), .rst(rst), .bus(if2), .ovf_sticky(st2), .sample_count(cn2));
  stream_accum_alu #(.WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0), .CNT_WIDTH(2)) u_cnt2 (
    .clk(clk), .rst(rst), .bus(if3), .ovf_sticky(st3), .sample_count(cn3));

  // Only the selected instance sees beats; the others drain freely.
  assign if0.in_valid  = in_valid && (sel == 2'd0);
  assign if0.out_ready = (sel == 2'd0) ? out_ready : 1'b1;
  assign if0.in_a = in_a;  assign if0.in_b = in_b;  assign if0.in_mode = in_mode;
  assign if1.in_valid  = in_valid && (sel == 2'd1);
  assign if1.out_ready = (sel == 2'd1) ? out_ready : 1'b1;
  assign if1.in_a = in_a;  assign if1.in_b = in_b;  assign if1.in_mode = in_mode;
  assign if2.in_valid  = in_valid && (sel == 2'd2);
  assign if2.out_ready = (sel == 2'd2) ? out_ready : 1'b1;
  assign if2.in_a = in_a;  assign if2.in_b = in_b;  assign if2.in_mode = in_mode;
  assign if3.in_valid  = in_valid && (sel == 2'd3);
  assign if3.out_ready = (sel == 2'd3) ? out_ready : 1'b1;
  assign if3.in_a = in_a;  assign if3.in_b = in_b;  assign if3.in_mode = in_mode;

  logic        act_in_ready, act_out_valid, act_carry, act_sticky;
  logic [15:0] act_data;
  logic [7:0]  act_count;

  always_comb begin
    act_in_ready  = if0.in_ready;
    act_out_valid = if0.out_valid;
    act_data      = if0.out_data;
    act_carry     = if0.out_carry;
    act_sticky    = st0;
    act_count     = cn0;
    case (sel)
      2'd1: begin
        act_in_ready = if1.in_ready; act_out_valid = if1.out_valid;
        act_data = 16'(if1.out_data); act_carry = if1.out_carry;
        act_sticky = st1; act_count = cn1;
      end
      2'd2: begin
        act_in_ready = if2.in_ready; act_out_valid = if2.out_valid;
        act_data = 16'(if2.out_data); act_carry = if2.out_carry;
        act_sticky = st2; act_count = cn2;
      end
      2'd3: begin
        act_in_ready = if3.in_ready; act_out_valid = if3.out_valid;
        act_data = if3.out_data; act_carry = if3.out_carry;
        act_sticky = st3; act_count = 8'(cn3);
      end
      default: ;
    endcase
  end

  int   errors = 0;
  int   checks = 0;
  int   nres   = 0;
  exp_t sb[$];
  vec_t tbl[$];

  logic        s_valid;
  logic [15:0] s_data;
  logic [7:0]  s_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, sample/score 1ns later, return at the rising edge.
  task automatic step(input logic v, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, output logic ok);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_mode = m; in_a = a; in_b = b; out_ready = ordy;
    #1;
    s_valid = act_out_valid; s_data = act_data; s_count = act_count;
    if (act_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got result 0x%0h, want none", act_data);
      end else begin
        e = sb.pop_front();
        check($sformatf("r%0d_data", nres), act_data, e.data);
        check($sformatf("r%0d_carry", nres), act_carry, e.carry);
        check($sformatf("r%0d_sticky", nres), act_sticky, e.sticky);
        check($sformatf("r%0d_count", nres), act_count, e.count);
        nres++;
      end
    end
    ok = in_valid && act_in_ready;
    @(posedge clk);
  endtask

  task automatic send(input vec_t v);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) step(1'b1, v.mode, v.a, v.b, 1'b1, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, want accept");
    end else begin
      sb.push_back('{v.data, v.carry, v.sticky, v.count});
    end
  endtask

  task automatic drain();
    logic ok;
    for (int k = 0; k < 10 && sb.size() != 0; k++) step(1'b0, M_ADD, 8'd0, 8'd0, 1'b1, ok);
    check("drain_empty", sb.size(), 0);
    @(negedge clk);
    #1;
    check("drain_idle_valid", act_out_valid, 0);
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic [1:0] m, input logic [7:0] a,
                              input logic [7:0] b, input logic [15:0] d, input logic c,
                              input logic st, input logic [7:0] n);
    vec_t v;
    v.sel = s; v.mode = m; v.a = a; v.b = b;
    v.data = d; v.carry = c; v.sticky = st; v.count = n;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = M_ADD;
    out_ready = 1'b1; sel = 2'd0;

    // Default parameters: ADD/SUB leave acc alone, ACC continues from LOAD.
    tbl.push_back(mk(0, M_LOAD, 8'd10,  8'd5,   16'h000F, 0, 0, 0));
    tbl.push_back(mk(0, M_ADD,  8'd200, 8'd100, 16'h012C, 1, 0, 0));
    tbl.push_back(mk(0, M_SUB,  8'd5,   8'd7,   16'h00FE, 1, 0, 0));
    tbl.push_back(mk(0, M_SUB,  8'd7,   8'd5,   16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, M_ACC,  8'd1,   8'd2,   16'h0012, 0, 0, 1));
    tbl.push_back(mk(0, M_ADD,  8'd255, 8'd255, 16'h01FE, 1, 0, 1));
    tbl.push_back(mk(0, M_SUB,  8'd0,   8'd0,   16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, M_ACC,  8'd255, 8'd255, 16'h0210, 0, 0, 2));
    // ACC_WIDTH=9, wrapping.
    tbl.push_back(mk(1, M_LOAD, 8'd255, 8'd255, 16'h01FE, 0, 0, 0));
    tbl.push_back(mk(1, M_ACC,  8'd1,   8'd1,   16'h0000, 1, 1, 1));
    tbl.push_back(mk(1, M_ADD,  8'd1,   8'd1,   16'h0002, 0, 1, 1));
    tbl.push_back(mk(1, M_ACC,  8'd3,   8'd0,   16'h0003, 0, 1, 2));
    tbl.push_back(mk(1, M_LOAD, 8'd0,   8'd0,   16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'd255, 8'd255, 16'h01FE, 0, 0, 0));
    tbl.push_back(mk(1, M_ACC,  8'd2,   8'd0,   16'h0000, 1, 1, 1));
    // ACC_WIDTH=9, saturating; overflow repeats once pinned at all-ones.
    tbl.push_back(mk(2, M_LOAD, 8'd255, 8'd255, 16'h01FE, 0, 0, 0));
    tbl.push_back(mk(2, M_ACC,  8'd1,   8'd1,   16'h01FF, 1, 1, 1));
    tbl.push_back(mk(2, M_ACC,  8'd1,   8'd0,   16'h01FF, 1, 1, 2));
    tbl.push_back(mk(2, M_SUB,  8'd3,   8'd9,   16'h00FA, 1, 1, 2));
    tbl.push_back(mk(2, M_LOAD, 8'd0,   8'd0,   16'h0000, 0, 0, 0));
    // CNT_WIDTH=2: sample_count wraps after 3.
    tbl.push_back(mk(3, M_LOAD, 8'd0,   8'd0,   16'h0000, 0, 0, 0));
    tbl.push_back(mk(3, M_ACC,  8'd1,   8'd0,   16'h0001, 0, 0, 1));
    tbl.push_back(mk(3, M_ACC,  8'd1,   8'd0,   16'h0002, 0, 0, 2));
    tbl.push_back(mk(3, M_ACC,  8'd1,   8'd0,   16'h0003, 0, 0, 3));
    tbl.push_back(mk(3, M_ACC,  8'd1,   8'd0,   16'h0004, 0, 0, 0));
    tbl.push_back(mk(3, M_ACC,  8'd1,   8'd0,   16'h0005, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", act_out_valid, 0);
    check("rst_out_data", act_data, 0);
    check("rst_out_carry", act_carry, 0);
    check("rst_sticky", act_sticky, 0);
    check("rst_count", act_count, 0);
    check("rst_in_ready", act_in_ready, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel != sel) begin
        drain();
        sel = tbl[i].sel;
      end
      send(tbl[i]);
    end
    drain();
    sel = 2'd0;

    // Backpressure: hold 0x0002 for five cycles, then consume and accept together.
    step(1'b1, M_ADD, 8'd1, 8'd1, 1'b0, ok);
    check("bp_first_accept", ok, 1);
    if (ok) sb.push_back('{16'h0002, 1'b0, 1'b0, 8'd2});
    for (int i = 0; i < 5; i++) begin
      step(1'b1, M_ADD, 8'd2, 8'd2, 1'b0, ok);
      check($sformatf("bp_stall%0d_accept", i), ok, 0);
      check($sformatf("bp_stall%0d_valid", i), s_valid, 1);
      check($sformatf("bp_stall%0d_data", i), s_data, 16'h0002);
    end
    step(1'b1, M_ADD, 8'd2, 8'd2, 1'b1, ok);
    check("bp_swap_accept", ok, 1);
    if (ok) sb.push_back('{16'h0004, 1'b0, 1'b0, 8'd2});
    step(1'b0, M_ADD, 8'd0, 8'd0, 1'b1, ok);
    check("bp_second_valid", s_valid, 1);
    check("bp_second_data", s_data, 16'h0004);
    drain();

    // Reset with a held result and a concurrent beat: everything returns to zero.
    step(1'b1, M_ACC, 8'd3, 8'd3, 1'b0, ok);
    check("rs_accept", ok, 1);
    step(1'b0, M_ADD, 8'd0, 8'd0, 1'b0, ok);
    check("rs_pending_valid", s_valid, 1);
    check("rs_pending_data", s_data, 16'h0216);
    check("rs_pending_count", s_count, 3);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_mode = M_LOAD; in_a = 8'h55; in_b = 8'h11; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_out_valid", act_out_valid, 0);
    check("mrst_out_data", act_data, 0);
    check("mrst_out_carry", act_carry, 0);
    check("mrst_count", act_count, 0);
    sel = 2'd1;
    #1;
    check("mrst_wrap9_sticky", act_sticky, 0);
    check("mrst_wrap9_count", act_count, 0);
    sel = 2'd0;
    send(mk(0, M_ACC, 8'd3, 8'd4, 16'h0007, 0, 0, 1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
